// File: rtl/bp_bht_pkg.sv
// Shared constants and types for the fetch-stage branch predictor.
package bp_bht_pkg;

   localparam int unsigned INST_ADDR_W = 32;
   localparam int unsigned HOLD_FLAG_W = 3;

   localparam logic [6:0] INST_TYPE_B = 7'b1100011;
   localparam logic [6:0] INST_JAL    = 7'b1101111;

   typedef enum logic [1:0] {
      KIND_OTHER,
      KIND_BRANCH,
      KIND_JAL
   } inst_kind_e;

endpackage

// File: rtl/bp_imm_dec.sv
// Opcode decode, B/J immediate extraction and branch target computation.
module bp_imm_dec
   import bp_bht_pkg::*;
(
   input  logic [31:0]            inst,
   input  logic [INST_ADDR_W-1:0] inst_addr,
   output inst_kind_e             kind,
   output logic                   imm_neg,
   output logic [INST_ADDR_W-1:0] target
);

   logic [31:0] imm;

   // Classify the instruction and select the matching sign-extended immediate.
   always_comb begin
      kind = KIND_OTHER;
      imm  = '0;
      case (inst[6:0])
         INST_TYPE_B: begin
            kind = KIND_BRANCH;
            imm  = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
         end
         INST_JAL: begin
            kind = KIND_JAL;
            imm  = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
         end
         default: ;
      endcase
   end

   // Bit 31 is the immediate sign for both B and J formats.
   assign imm_neg = inst[31];
   assign target  = inst_addr + imm;

endmodule

// File: rtl/bp_bht.sv
// Dynamic branch predictor: tagged table of saturating counters with BTFN
// fallback, trained by EX resolution, plus branch/mispredict perf counters.
module bp_bht
   import bp_bht_pkg::*;
#(
   parameter int unsigned ENTRIES = 16,
   parameter int unsigned CNT_W   = 2,
   parameter int unsigned TAG_W   = 8,
   parameter int unsigned MODE    = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [31:0]            inst_i,
   input  logic [INST_ADDR_W-1:0] inst_addr_i,
   input  logic [HOLD_FLAG_W-1:0] hold_flag_i,
   output logic                   isbranch_o,
   output logic [INST_ADDR_W-1:0] branch_addr_o,
   input  logic                   upd_valid_i,
   input  logic [INST_ADDR_W-1:0] upd_pc_i,
   input  logic                   upd_taken_i,
   input  logic                   upd_mispredict_i,
   input  logic                   flush_i,
   output logic [31:0]            perf_branch_cnt_o,
   output logic [31:0]            perf_mispred_cnt_o
);

   localparam int unsigned    IDX_W       = $clog2(ENTRIES);
   localparam int unsigned    TAG_SW      = (TAG_W > 0) ? TAG_W : 1;
   localparam logic [CNT_W-1:0] CNT_MAX     = '1;
   localparam logic [CNT_W-1:0] CNT_WEAK_T  = CNT_W'(1) << (CNT_W - 1);
   localparam logic [CNT_W-1:0] CNT_WEAK_NT = CNT_WEAK_T - CNT_W'(1);

   logic              valid_q [ENTRIES];
   logic [TAG_SW-1:0] tag_q   [ENTRIES];
   logic [CNT_W-1:0]  cnt_q   [ENTRIES];

   logic [31:0] perf_branch_q;
   logic [31:0] perf_mispred_q;

   inst_kind_e             kind;
   logic                   imm_neg;
   logic [INST_ADDR_W-1:0] target;

   logic [IDX_W-1:0]  fetch_idx, upd_idx;
   logic [31:0]       fetch_sh, upd_sh;
   logic [TAG_SW-1:0] fetch_tag, upd_tag;
   logic              fetch_hit, upd_hit;
   logic [CNT_W-1:0]  cnt_nxt;
   logic              unused_bits;

   bp_imm_dec u_dec (
      .inst      (inst_i),
      .inst_addr (inst_addr_i),
      .kind      (kind),
      .imm_neg   (imm_neg),
      .target    (target)
   );

   assign fetch_idx = inst_addr_i[IDX_W+1:2];
   assign upd_idx   = upd_pc_i[IDX_W+1:2];
   assign fetch_sh  = inst_addr_i >> (IDX_W + 2);
   assign upd_sh    = upd_pc_i >> (IDX_W + 2);
   assign fetch_tag = fetch_sh[TAG_SW-1:0];
   assign upd_tag   = upd_sh[TAG_SW-1:0];
   assign unused_bits = ^{fetch_sh, upd_sh};

   // With TAG_W = 0 every valid entry is a hit.
   assign fetch_hit = valid_q[fetch_idx] && ((TAG_W == 0) || (tag_q[fetch_idx] == fetch_tag));
   assign upd_hit   = valid_q[upd_idx]   && ((TAG_W == 0) || (tag_q[upd_idx]   == upd_tag));

   // Prediction from decode plus pre-update table contents; quiet during reset.
   always_comb begin
      isbranch_o    = 1'b0;
      branch_addr_o = '0;
      case (kind)
         KIND_JAL: begin
            isbranch_o    = 1'b1;
            branch_addr_o = target;
         end
         KIND_BRANCH: begin
            branch_addr_o = target;
            if ((MODE == 1) && fetch_hit)
               isbranch_o = cnt_q[fetch_idx][CNT_W-1];
            else
               isbranch_o = imm_neg;
         end
         default: ;
      endcase
      if (hold_flag_i != '0)
         isbranch_o = 1'b0;
      if (rst) begin
         isbranch_o    = 1'b0;
         branch_addr_o = '0;
      end
   end

   // Next counter value: saturating step on hit, weak allocation on miss.
   always_comb begin
      cnt_nxt = cnt_q[upd_idx];
      if (upd_hit) begin
         if (upd_taken_i) begin
            if (cnt_q[upd_idx] != CNT_MAX)
               cnt_nxt = cnt_q[upd_idx] + CNT_W'(1);
         end else begin
            if (cnt_q[upd_idx] != '0)
               cnt_nxt = cnt_q[upd_idx] - CNT_W'(1);
         end
      end else begin
         cnt_nxt = upd_taken_i ? CNT_WEAK_T : CNT_WEAK_NT;
      end
   end

   // Table state: flush clears valid bits only and drops a coincident update.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < ENTRIES; i++) begin
            valid_q[i] <= 1'b0;
            tag_q[i]   <= '0;
            cnt_q[i]   <= '0;
         end
      end else if (flush_i) begin
         for (int unsigned i = 0; i < ENTRIES; i++)
            valid_q[i] <= 1'b0;
      end else if ((MODE == 1) && upd_valid_i) begin
         valid_q[upd_idx] <= 1'b1;
         tag_q[upd_idx]   <= upd_tag;
         cnt_q[upd_idx]   <= cnt_nxt;
      end
   end

   // Saturating performance counters, independent of MODE and flush.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_branch_q  <= '0;
         perf_mispred_q <= '0;
      end else if (upd_valid_i) begin
         if (perf_branch_q != '1)
            perf_branch_q <= perf_branch_q + 32'd1;
         if (upd_mispredict_i && (perf_mispred_q != '1))
            perf_mispred_q <= perf_mispred_q + 32'd1;
      end
   end

   assign perf_branch_cnt_o  = perf_branch_q;
   assign perf_mispred_cnt_o = perf_mispred_q;

endmodule

// File: doc/bp_bht.md
Name: bp_bht

Overview:
- Parametrised dynamic branch predictor for the tinyriscv fetch stage; successor to the single-mode static predictor.
- Decodes the fetched instruction and computes the branch/JAL target from its immediate.
- Predicts conditional-branch direction from a tagged table of saturating counters, trained by EX resolution.
- Feeds isbranch/branch_addr to pc_reg and if_id, and exposes branch and mispredict performance counters.

Parameters:
- ENTRIES, 16, number of table entries; power of two, 2..256.
- CNT_W, 2, saturating counter width; 1..4.
- TAG_W, 8, tag bits stored per entry; 0 disables tagging (every valid entry hits).
- MODE, 1, 0 = static BTFN only (table never consulted), 1 = dynamic table with BTFN fallback on miss.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous active-high reset
- inst_i  in  32  fetched instruction (rib_pc_data_i)
- inst_addr_i  in  32  fetch PC (pc_pc_o)
- hold_flag_i  in  3  ctrl hold flag (Hold_Flag_Bus)
- isbranch_o  out  1  predict taken; redirect PC
- branch_addr_o  out  32  predicted target
- upd_valid_i  in  1  EX resolved a conditional branch this cycle
- upd_pc_i  in  32  PC of the resolved branch
- upd_taken_i  in  1  actual outcome
- upd_mispredict_i  in  1  EX prediction was wrong (ex_branch_taken_o mismatch)
- flush_i  in  1  clear table (jtag_reset_flag_i)
- perf_branch_cnt_o  out  32  resolved conditional branches
- perf_mispred_cnt_o  out  32  mispredicted conditional branches

Behaviour:
- Reset (async, rst=1): all valid bits 0, counters 0, tags 0, both perf counters 0. isbranch_o = 0 and branch_addr_o = 0 while rst is high.
- Index = PC[IDX_W+1:2], with IDX_W = log2(ENTRIES). Tag = PC[IDX_W+1+TAG_W : IDX_W+2].

Lookup (combinational, same cycle as fetch):
- JAL (opcode 1101111): isbranch_o = 1, target = inst_addr_i + sign-extended J-immediate.
- Conditional branch (opcode 1100011): target = inst_addr_i + sign-extended B-immediate.
  - MODE=0, or table miss: taken iff imm < 0 (BTFN).
  - Hit (valid and tag match): taken = counter MSB.
- Any other opcode: isbranch_o = 0, branch_addr_o = 0.
- hold_flag_i != 0: isbranch_o forced 0; branch_addr_o still driven.

Update (at the clock edge when upd_valid_i = 1 and MODE = 1):
- Hit: counter +1 if taken, -1 if not taken, saturating at 0 and 2^CNT_W - 1.
- Miss: allocate the entry: valid = 1, tag written, counter = 2^(CNT_W-1) if taken (weakly taken), else 2^(CNT_W-1) - 1 (weakly not taken). For CNT_W=1 the counter is simply set to the outcome.
- A lookup and an update to the same index in the same cycle: the lookup sees the pre-update value (write-first is forbidden).

Perf counters (run in both modes):
- perf_branch_cnt_o += 1 on upd_valid_i.
- perf_mispred_cnt_o += 1 on upd_valid_i && upd_mispredict_i.
- Both saturate at 0xFFFFFFFF; they do not wrap.

flush_i (synchronous):
- Clears all valid bits next edge; counters keep their value.
- Has priority over a simultaneous update, which is dropped.
- Perf counters are unaffected.

Decomposition:
- Shared package (defines.v): opcode constants INST_TYPE_B and INST_JAL, Hold_Flag_Bus, InstAddrBus.
- Local constants: IDX_W, CNT_MAX, CNT_WEAK_T, CNT_WEAK_NT.
- One natural sub-module, bp_imm_dec: combinational opcode decode plus B/J immediate extraction and target add.
- Table and counters live in bp_bht itself.

Test Plan:
- Reset then fetch BEQ at 0x100 with imm -8, MODE=1, cold table -> isbranch_o=1, branch_addr_o=0x0F8 (BTFN); imm +16 -> isbranch_o=0.
- Resolve the branch at 0x100 not-taken twice, then taken once (CNT_W=2) -> counter goes 1 (alloc), 0, then 1. Lookup yields not-taken throughout; perf_branch_cnt_o=3.
- Two PCs with the same index and different tags (0x100 and 0x100+4*ENTRIES) -> the second update reallocates the entry, and the first PC reverts to BTFN prediction.
- Same-cycle lookup and update at the same index moving the counter from 1 to 2 -> that cycle predicts not-taken, the next cycle predicts taken.
- JAL at 0x200 with imm +0x40 and hold_flag_i=3'b001 -> isbranch_o=0; with hold_flag_i=0 -> isbranch_o=1, branch_addr_o=0x240.
- flush_i together with upd_valid_i -> entry stays invalid; mispredict pulses increment perf_mispred_cnt_o; counter preloaded to 0xFFFFFFFE saturates at 0xFFFFFFFF; asserting rst mid-run clears everything immediately.
